// File: rtl/rv32_instr_encoder.sv
// Streaming RV32I instruction encoder: command in, 32-bit instruction word out, both over valid/ready.
// Define RV_ENC_LI_EN to enable LI (load 32-bit immediate) expansion into LUI+ADDI.
module rv32_instr_encoder #(
  parameter int CNT_W       = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [2:0]       cmd_funct3,
  input  logic             cmd_f7b5,
  input  logic [4:0]       cmd_rd,
  input  logic [4:0]       cmd_rs1,
  input  logic [4:0]       cmd_rs2,
  input  logic [31:0]      cmd_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_data,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        inIdle;
  logic        cmdFire;
  logic        outFire;
  logic [31:0] encWord;
  logic        encIllegal;
  logic        liLoad;
  logic [31:0] liAddi;

`ifdef RV_ENC_LI_EN
  typedef enum logic {IDLE, LI2} state_t;
  state_t      state, stateNext;
  logic        liTwo;
  logic [31:0] addiWord;
  logic        liFits12;
  logic [19:0] liUpper;

  assign liFits12 = (&cmd_imm[31:11]) || !(|cmd_imm[31:11]);
  // Upper part rounded so that the sign-extended ADDI low part lands on the exact value.
  assign liUpper  = cmd_imm[31:12] + {19'd0, cmd_imm[11]};
`endif

  assign cmd_ready = !rst && inIdle && (!instr_valid || instr_ready);
  assign cmdFire   = cmd_valid && cmd_ready;
  assign outFire   = instr_valid && instr_ready;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    encWord    = '0;
    encIllegal = 1'b0;
`ifdef RV_ENC_LI_EN
    liTwo      = 1'b0;
    addiWord   = '0;
`endif
    case (cmd_op)
      4'd0: encWord = {1'b0, cmd_f7b5, 5'b0, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, OP_ALUREG};
      4'd1: begin
        if (cmd_funct3 == 3'b001 || cmd_funct3 == 3'b101)
          encWord = {1'b0, cmd_f7b5, 5'b0, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, OP_ALUIMM};
        else
          encWord = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_ALUIMM};
      end
      4'd2: encWord = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_LOAD};
      4'd3: encWord = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], OP_STORE};
      4'd4: begin
        encWord    = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                      cmd_imm[4:1], cmd_imm[11], OP_BRANCH};
        encIllegal = CHECK_ALIGN && cmd_imm[0];
      end
      4'd5: encWord = {cmd_imm[31:12], cmd_rd, OP_LUI};
      4'd6: encWord = {cmd_imm[31:12], cmd_rd, OP_AUIPC};
      4'd7: begin
        encWord    = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OP_JAL};
        encIllegal = CHECK_ALIGN && cmd_imm[0];
      end
      4'd8: encWord = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, OP_JALR};
      4'd9: encWord = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_SYSTEM};
      4'd10: begin
`ifdef RV_ENC_LI_EN
        addiWord = {cmd_imm[11:0], cmd_rd, 3'b000, cmd_rd, OP_ALUIMM};
        if (liFits12) begin
          encWord = {cmd_imm[11:0], 5'd0, 3'b000, cmd_rd, OP_ALUIMM};
        end else begin
          encWord = {liUpper, cmd_rd, OP_LUI};
          liTwo   = (cmd_imm[11:0] != 12'd0);
        end
`else
        encIllegal = 1'b1;
`endif
      end
      default: encIllegal = 1'b1;
    endcase
  end

`ifdef RV_ENC_LI_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (cmdFire && liTwo) stateNext = LI2;
      LI2:     if (outFire) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  liAddi <= '0;
    else if (cmdFire && liTwo) liAddi <= addiWord;
  end

  assign inIdle = (state == IDLE);
  // The pending ADDI replaces the LUI word on the very edge the LUI is taken.
  assign liLoad = (state == LI2) && outFire;
`else
  assign inIdle = 1'b1;
  assign liLoad = 1'b0;
  assign liAddi = '0;
`endif

  // NOTE: sequential state is written with non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr_data  <= '0;
      err         <= 1'b0;
      word_count  <= '0;
    end else begin
      err <= cmdFire && encIllegal;
      if (outFire) word_count <= word_count + CNT_W'(1);
      if (cmdFire && !encIllegal) begin
        instr_valid <= 1'b1;
        instr_data  <= encWord;
      end else if (liLoad) begin
        instr_data  <= liAddi;
      end else if (outFire) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
